// File: rtl/fmul_issue_arbiter_if.sv
// Requester, pipeline and response signals shared between the issue arbiter and its environment.
interface fmul_issue_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [32*N_REQ-1:0] req_a;
    logic [32*N_REQ-1:0] req_b;
    logic                pipe_valid;
    logic [31:0]         pipe_a;
    logic [31:0]         pipe_b;
    logic [31:0]         pipe_res;
    logic                pipe_ovf;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [ID_W-1:0]     rsp_id;
    logic [31:0]         rsp_data;
    logic                rsp_ovf;

    modport slave (
        input  req_valid, req_a, req_b, pipe_res, pipe_ovf, rsp_ready,
        output req_ready, pipe_valid, pipe_a, pipe_b, rsp_valid, rsp_id, rsp_data, rsp_ovf
    );

    modport master (
        output req_valid, req_a, req_b, pipe_res, pipe_ovf, rsp_ready,
        input  req_ready, pipe_valid, pipe_a, pipe_b, rsp_valid, rsp_id, rsp_data, rsp_ovf
    );
endinterface

// File: rtl/fmul_issue_arbiter.sv
// Round-robin issue into a shared fmul pipe, tag line, response FIFO; FMUL_ARB_OVF_COUNT_EN adds ovf_count.
// Latency: accept to rsp_valid is LATENCY+2 cycles minimum.
// Backpressure: issue stalls while inflight+fifo_count reaches FIFO_DEPTH, so the FIFO never overflows.
module fmul_issue_arbiter #(
    parameter int N_REQ      = 4,
    parameter int LATENCY    = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int ID_W       = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    fmul_issue_arbiter_if.slave bus
`ifdef FMUL_ARB_OVF_COUNT_EN
    ,
    output logic [15:0]         ovf_count
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } tag_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [31:0]     data;
        logic            ovf;
    } rsp_t;

    logic [ID_W-1:0]    rr_ptr;
    logic [CNT_W-1:0]   inflight;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W-1:0]   count_nxt;
    logic [CNT_W:0]     outstanding;
    logic               grant_allowed;
    logic               grant;
    logic               found;
    logic [ID_W:0]      wsum;
    logic [ID_W-1:0]    win;
    logic [2*N_REQ-1:0] dbl_valid;
    logic [N_REQ-1:0]   rot_valid;
    logic [N_REQ-1:0]   ready_vec;
    logic [31:0]        sel_a;
    logic [31:0]        sel_b;

    logic               pipe_valid_q;
    logic [31:0]        pipe_a_q;
    logic [31:0]        pipe_b_q;
    logic [ID_W-1:0]    issue_id;
    tag_t               tags [LATENCY];
    logic               push;
    logic               pop;
    rsp_t               wdat;
    rsp_t               mem [FIFO_DEPTH];
    rsp_t               head;
    rsp_t               head_nxt;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   rd_ptr_nxt;

    assign outstanding   = {1'b0, inflight} + {1'b0, fifo_count};
    assign grant_allowed = outstanding < (CNT_W+1)'(FIFO_DEPTH);

    // Rotate the valid vector so bit 0 is the requester at rr_ptr.
    assign dbl_valid = {bus.req_valid, bus.req_valid};
    assign rot_valid = N_REQ'(dbl_valid >> rr_ptr);

    always_comb begin
        found = 1'b0;
        wsum  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && rot_valid[k]) begin
                found = 1'b1;
                wsum  = {1'b0, rr_ptr} + (ID_W+1)'(k);
            end
        end
        win = (wsum >= (ID_W+1)'(N_REQ)) ? ID_W'(wsum - (ID_W+1)'(N_REQ)) : ID_W'(wsum);
    end

    assign grant = grant_allowed & found;

    always_comb begin
        ready_vec = '0;
        sel_a     = '0;
        sel_b     = '0;
        if (grant) ready_vec[win] = 1'b1;
        for (int k = 0; k < N_REQ; k++) begin
            if (win == ID_W'(k)) begin
                sel_a = bus.req_a[32*k +: 32];
                sel_b = bus.req_b[32*k +: 32];
            end
        end
    end

    assign push = tags[LATENCY-1].vld;
    assign pop  = bus.rsp_valid & bus.rsp_ready;
    assign wdat = '{id: tags[LATENCY-1].id, data: bus.pipe_res, ovf: bus.pipe_ovf};

    always_comb begin
        count_nxt  = fifo_count;
        if (push && !pop) count_nxt = fifo_count + 1'b1;
        if (!push && pop) count_nxt = fifo_count - 1'b1;
        rd_ptr_nxt = rd_ptr + PTR_W'(pop);
        // The new head may be the entry being written this very cycle.
        head_nxt   = (push && wr_ptr == rd_ptr_nxt) ? wdat : mem[rd_ptr_nxt];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr       <= '0;
            pipe_valid_q <= 1'b0;
            pipe_a_q     <= '0;
            pipe_b_q     <= '0;
            issue_id     <= '0;
            inflight     <= '0;
            fifo_count   <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            head         <= '0;
            for (int i = 0; i < LATENCY; i++) tags[i] <= '0;
        end else begin
            pipe_valid_q <= grant;
            if (grant) begin
                rr_ptr   <= (win == ID_W'(N_REQ-1)) ? '0 : win + 1'b1;
                pipe_a_q <= sel_a;
                pipe_b_q <= sel_b;
                issue_id <= win;
            end
            tags[0] <= '{vld: pipe_valid_q, id: issue_id};
            for (int i = 1; i < LATENCY; i++) tags[i] <= tags[i-1];
            if (grant && !push) inflight <= inflight + 1'b1;
            if (!grant && push) inflight <= inflight - 1'b1;
            fifo_count <= count_nxt;
            rd_ptr     <= rd_ptr_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (count_nxt != '0) head <= head_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdat;
    end

    assert property (@(posedge clk) disable iff (!rst_n) push |-> (fifo_count != CNT_W'(FIFO_DEPTH)));

`ifdef FMUL_ARB_OVF_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_count <= '0;
        else if (push && bus.pipe_ovf && ovf_count != 16'hFFFF) ovf_count <= ovf_count + 1'b1;
    end
`endif

    assign bus.req_ready  = ready_vec;
    assign bus.pipe_valid = pipe_valid_q;
    assign bus.pipe_a     = pipe_a_q;
    assign bus.pipe_b     = pipe_b_q;
    assign bus.rsp_valid  = (fifo_count != '0);
    assign bus.rsp_id     = head.id;
    assign bus.rsp_data   = head.data;
    assign bus.rsp_ovf    = head.ovf;
endmodule
